// File: rtl/gmux_hsck_seq.sv
// Glitch-safe sequencer for the high-speed global clock mux. It gates the quadrants,
// switches the select, waits for the mux to settle, then re-enables the quadrants.
module gmux_hsck_seq #(
  parameter int GATE_CYC   = 4,
  parameter int SETTLE_CYC = 8,
  parameter int CNT_W      = 8
) (
  input  logic       CLK,
  input  logic       RSTN,
  input  logic       SEL_REQ,
  input  logic [3:0] QEN_REQ,
  input  logic       VLP_REQ,
  input  logic       DYN_EN,
  input  logic [3:0] DYN_GATE,
  output logic       SSEL,
  output logic [3:0] SEN,
  output logic [3:0] DYNEN,
  output logic [3:0] DEN,
  output logic [3:0] VLP,
  output logic       BUSY,
  output logic       DONE,
  output logic       HSCK_STATIC
);

  // state    | meaning
  // S_IDLE   | outputs stable, requests compared against current outputs
  // S_GATE   | all quadrants gated, waiting GATE_CYC cycles before the select may move
  // S_SWITCH | select changed, waiting SETTLE_CYC cycles for the mux to settle
  // S_DONE   | targets applied, one-cycle completion pulse
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_GATE   = 2'd1,
    S_SWITCH = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tgt_sel_q, tgt_sel_d;
  logic [3:0]       tgt_sen_q, tgt_sen_d;
  logic [3:0]       tgt_vlp_q, tgt_vlp_d;

  logic             ssel_d;
  logic [3:0]       sen_d, vlp_d, dynen_d, den_d;
  logic             busy_d, done_d, hsck_d;

  logic [3:0]       req_sen, req_vlp;
  logic             pending, additive;

  always_comb begin
    req_sen  = VLP_REQ ? 4'h0 : QEN_REQ;
    req_vlp  = {4{VLP_REQ}};
    pending  = (SEL_REQ != SSEL) || (req_sen != SEN) || (req_vlp != VLP);
    // Adding quadrants under an unchanged select cannot glitch the running ones.
    additive = (SEL_REQ == SSEL) && (VLP == 4'h0) && (req_vlp == 4'h0) &&
               ((req_sen & SEN) == SEN);

    state_d   = state_q;
    cnt_d     = cnt_q;
    tgt_sel_d = tgt_sel_q;
    tgt_sen_d = tgt_sen_q;
    tgt_vlp_d = tgt_vlp_q;
    ssel_d    = SSEL;
    sen_d     = SEN;
    vlp_d     = VLP;

    case (state_q)
      S_IDLE: begin
        if (pending) begin
          tgt_sel_d = SEL_REQ;
          tgt_sen_d = req_sen;
          tgt_vlp_d = req_vlp;
          if (additive) begin
            sen_d   = req_sen;
            state_d = S_DONE;
          end else begin
            sen_d   = 4'h0;
            cnt_d   = CNT_W'(GATE_CYC - 1);
            state_d = S_GATE;
          end
        end
      end
      S_GATE: begin
        if (cnt_q == '0) begin
          if (tgt_sel_q != SSEL) begin
            ssel_d  = tgt_sel_q;
            cnt_d   = CNT_W'(SETTLE_CYC - 1);
            state_d = S_SWITCH;
          end else begin
            sen_d   = tgt_sen_q;
            vlp_d   = tgt_vlp_q;
            state_d = S_DONE;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_SWITCH: begin
        if (cnt_q == '0) begin
          sen_d   = tgt_sen_q;
          vlp_d   = tgt_vlp_q;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Derived outputs come from next-state values so every flop agrees in the same cycle.
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
    dynen_d = {4{DYN_EN}} & sen_d;
    den_d   = busy_d ? 4'h0 : (DYN_GATE & dynen_d);
    hsck_d  = ssel_d && (sen_d == 4'hF) && (den_d == 4'h0) && (vlp_d == 4'h0);
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      tgt_sel_q   <= 1'b0;
      tgt_sen_q   <= 4'h0;
      tgt_vlp_q   <= 4'h0;
      SSEL        <= 1'b0;
      SEN         <= 4'h0;
      DYNEN       <= 4'h0;
      DEN         <= 4'h0;
      VLP         <= 4'h0;
      BUSY        <= 1'b0;
      DONE        <= 1'b0;
      HSCK_STATIC <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tgt_sel_q   <= tgt_sel_d;
      tgt_sen_q   <= tgt_sen_d;
      tgt_vlp_q   <= tgt_vlp_d;
      SSEL        <= ssel_d;
      SEN         <= sen_d;
      DYNEN       <= dynen_d;
      DEN         <= den_d;
      VLP         <= vlp_d;
      BUSY        <= busy_d;
      DONE        <= done_d;
      HSCK_STATIC <= hsck_d;
    end
  end

endmodule

// File: tb/tb_gmux_hsck_seq.sv
// Bench for gmux_hsck_seq: directed vector table, hand-written corner sequences and
// random requests checked against a frame-schedule reference model.
module tb_gmux_hsck_seq;
  localparam int GATE_CYC   = 4;
  localparam int SETTLE_CYC = 8;

  logic       CLK = 1'b0;
  logic       RSTN = 1'b0;
  logic       SEL_REQ = 1'b0;
  logic [3:0] QEN_REQ = 4'h0;
  logic       VLP_REQ = 1'b0;
  logic       DYN_EN = 1'b0;
  logic [3:0] DYN_GATE = 4'h0;
  logic       SSEL;
  logic [3:0] SEN, DYNEN, DEN, VLP;
  logic       BUSY, DONE, HSCK_STATIC;

  always #5 CLK = ~CLK;

  gmux_hsck_seq #(.GATE_CYC(GATE_CYC), .SETTLE_CYC(SETTLE_CYC), .CNT_W(8)) dut (
    .CLK(CLK), .RSTN(RSTN), .SEL_REQ(SEL_REQ), .QEN_REQ(QEN_REQ), .VLP_REQ(VLP_REQ),
    .DYN_EN(DYN_EN), .DYN_GATE(DYN_GATE), .SSEL(SSEL), .SEN(SEN), .DYNEN(DYNEN),
    .DEN(DEN), .VLP(VLP), .BUSY(BUSY), .DONE(DONE), .HSCK_STATIC(HSCK_STATIC)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: each sequence is expanded into the list of per-cycle output frames.
  typedef struct packed {
    logic       sel;
    logic [3:0] sen;
    logic [3:0] vlp;
    logic       busy;
    logic       done;
  } frame_t;

  frame_t     plan[$];
  logic       m_sel = 1'b0;
  logic [3:0] m_sen = 4'h0, m_vlp = 4'h0, m_dynen = 4'h0, m_den = 4'h0;
  logic       m_busy = 1'b0, m_done = 1'b0, m_hsck = 1'b0;

  function automatic frame_t mkf(logic sel, logic [3:0] sen, logic [3:0] vlp,
                                 logic busy, logic done);
    frame_t f;
    f.sel = sel; f.sen = sen; f.vlp = vlp; f.busy = busy; f.done = done;
    return f;
  endfunction

  task automatic model_edge();
    frame_t     f;
    logic [3:0] tsen, tvlp;
    bit         pend, additive;
    if (!RSTN) begin
      plan.delete();
      m_sel = 0; m_sen = 0; m_vlp = 0; m_busy = 0; m_done = 0;
      m_dynen = 0; m_den = 0; m_hsck = 0;
    end else begin
      if (plan.size() == 0) begin
        tsen = VLP_REQ ? 4'h0 : QEN_REQ;
        tvlp = VLP_REQ ? 4'hF : 4'h0;
        pend = (SEL_REQ != m_sel) || (tsen != m_sen) || (tvlp != m_vlp);
        if (pend) begin
          additive = (SEL_REQ == m_sel) && (m_vlp == 4'h0) && (tvlp == 4'h0) &&
                     ((tsen | m_sen) == tsen);
          if (!additive) begin
            repeat (GATE_CYC) plan.push_back(mkf(m_sel, 4'h0, m_vlp, 1'b1, 1'b0));
            if (SEL_REQ != m_sel)
              repeat (SETTLE_CYC) plan.push_back(mkf(SEL_REQ, 4'h0, m_vlp, 1'b1, 1'b0));
          end
          plan.push_back(mkf(SEL_REQ, tsen, tvlp, 1'b1, 1'b1));
          plan.push_back(mkf(SEL_REQ, tsen, tvlp, 1'b0, 1'b0));
        end
      end
      if (plan.size() != 0) begin
        f = plan.pop_front();
        m_sel = f.sel; m_sen = f.sen; m_vlp = f.vlp; m_busy = f.busy; m_done = f.done;
      end
      m_dynen = DYN_EN ? m_sen : 4'h0;
      m_den   = m_busy ? 4'h0 : (DYN_GATE & m_dynen);
      m_hsck  = m_sel && (m_sen == 4'hF) && (m_den == 4'h0) && (m_vlp == 4'h0);
    end
  endtask

  function automatic logic [19:0] mk(logic ssel, logic [3:0] sen, logic [3:0] dynen,
                                     logic [3:0] den, logic [3:0] vlp, logic busy,
                                     logic done, logic hsck);
    return {ssel, sen, dynen, den, vlp, busy, done, hsck};
  endfunction

  function automatic logic [19:0] dut_vec();
    return {SSEL, SEN, DYNEN, DEN, VLP, BUSY, DONE, HSCK_STATIC};
  endfunction

  function automatic logic [19:0] model_vec();
    return {m_sel, m_sen, m_dynen, m_den, m_vlp, m_busy, m_done, m_hsck};
  endfunction

  task automatic check(input string name, input logic [19:0] act, input logic [19:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got ssel/sen/dynen/den/vlp/busy/done/hsck=%h required %h @%0t",
               name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    model_edge();
    #1;
    check("model", dut_vec(), model_vec());
  endtask

  typedef struct {
    logic       rstn;
    logic       sel;
    logic [3:0] qen;
    logic       vlp;
    logic       dyn_en;
    logic [3:0] dyn_gate;
    int         edges;
    logic [19:0] exp;
  } vec_t;

  vec_t tv[$];

  task automatic addv(input logic rstn, input logic sel, input logic [3:0] qen,
                      input logic vlp, input logic dyn_en, input logic [3:0] dyn_gate,
                      input int edges, input logic [19:0] exp);
    vec_t v;
    v.rstn = rstn; v.sel = sel; v.qen = qen; v.vlp = vlp; v.dyn_en = dyn_en;
    v.dyn_gate = dyn_gate; v.edges = edges; v.exp = exp;
    tv.push_back(v);
  endtask

  initial begin
    // reset and quiet idle
    addv(0, 0, 4'h0, 0, 0, 4'h0, 2, mk(0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 0));
    addv(1, 0, 4'h0, 0, 0, 4'h0, 3, mk(0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 0));
    // select change: gate at edge 1, SSEL at edge 5, enable at edge 13, idle at 14
    addv(1, 1, 4'hF, 0, 0, 4'h0, 1, mk(0, 4'h0, 4'h0, 4'h0, 4'h0, 1, 0, 0));
    addv(1, 1, 4'hF, 0, 0, 4'h0, 3, mk(0, 4'h0, 4'h0, 4'h0, 4'h0, 1, 0, 0));
    addv(1, 1, 4'hF, 0, 0, 4'h0, 1, mk(1, 4'h0, 4'h0, 4'h0, 4'h0, 1, 0, 0));
    addv(1, 1, 4'hF, 0, 0, 4'h0, 7, mk(1, 4'h0, 4'h0, 4'h0, 4'h0, 1, 0, 0));
    addv(1, 1, 4'hF, 0, 0, 4'h0, 1, mk(1, 4'hF, 4'h0, 4'h0, 4'h0, 1, 1, 1));
    addv(1, 1, 4'hF, 0, 0, 4'h0, 1, mk(1, 4'hF, 4'h0, 4'h0, 4'h0, 0, 0, 1));
    // removal of quadrants is gated
    addv(1, 1, 4'h3, 0, 0, 4'h0, 5, mk(1, 4'h3, 4'h0, 4'h0, 4'h0, 1, 1, 0));
    addv(1, 1, 4'h3, 0, 0, 4'h0, 1, mk(1, 4'h3, 4'h0, 4'h0, 4'h0, 0, 0, 0));
    // additive path completes in one edge
    addv(1, 1, 4'h7, 0, 0, 4'h0, 1, mk(1, 4'h7, 4'h0, 4'h0, 4'h0, 1, 1, 0));
    addv(1, 1, 4'h7, 0, 0, 4'h0, 1, mk(1, 4'h7, 4'h0, 4'h0, 4'h0, 0, 0, 0));
    addv(1, 1, 4'h1, 0, 0, 4'h0, 1, mk(1, 4'h0, 4'h0, 4'h0, 4'h0, 1, 0, 0));
    addv(1, 1, 4'h1, 0, 0, 4'h0, 3, mk(1, 4'h0, 4'h0, 4'h0, 4'h0, 1, 0, 0));
    addv(1, 1, 4'h1, 0, 0, 4'h0, 1, mk(1, 4'h1, 4'h0, 4'h0, 4'h0, 1, 1, 0));
    addv(1, 1, 4'h1, 0, 0, 4'h0, 1, mk(1, 4'h1, 4'h0, 4'h0, 4'h0, 0, 0, 0));
    addv(1, 1, 4'hF, 0, 0, 4'h0, 1, mk(1, 4'hF, 4'h0, 4'h0, 4'h0, 1, 1, 1));
    addv(1, 1, 4'hF, 0, 0, 4'h0, 1, mk(1, 4'hF, 4'h0, 4'h0, 4'h0, 0, 0, 1));
    // VLP entry and exit
    addv(1, 1, 4'hF, 1, 0, 4'h0, 4, mk(1, 4'h0, 4'h0, 4'h0, 4'h0, 1, 0, 0));
    addv(1, 1, 4'hF, 1, 0, 4'h0, 1, mk(1, 4'h0, 4'h0, 4'h0, 4'hF, 1, 1, 0));
    addv(1, 1, 4'hF, 1, 0, 4'h0, 1, mk(1, 4'h0, 4'h0, 4'h0, 4'hF, 0, 0, 0));
    addv(1, 1, 4'hF, 0, 0, 4'h0, 4, mk(1, 4'h0, 4'h0, 4'h0, 4'hF, 1, 0, 0));
    addv(1, 1, 4'hF, 0, 0, 4'h0, 1, mk(1, 4'hF, 4'h0, 4'h0, 4'h0, 1, 1, 1));
    addv(1, 1, 4'hF, 0, 0, 4'h0, 1, mk(1, 4'hF, 4'h0, 4'h0, 4'h0, 0, 0, 1));
    // dynamic gating in idle, suppressed while busy
    addv(1, 1, 4'hF, 0, 1, 4'h5, 1, mk(1, 4'hF, 4'hF, 4'h5, 4'h0, 0, 0, 0));
    addv(1, 1, 4'hF, 0, 1, 4'h0, 1, mk(1, 4'hF, 4'hF, 4'h0, 4'h0, 0, 0, 1));
    addv(1, 1, 4'h3, 0, 1, 4'hF, 1, mk(1, 4'h0, 4'h0, 4'h0, 4'h0, 1, 0, 0));
    addv(1, 1, 4'h3, 0, 1, 4'hF, 4, mk(1, 4'h3, 4'h3, 4'h0, 4'h0, 1, 1, 0));
    addv(1, 1, 4'h3, 0, 1, 4'hF, 1, mk(1, 4'h3, 4'h3, 4'h3, 4'h0, 0, 0, 0));

    foreach (tv[i]) begin
      RSTN = tv[i].rstn; SEL_REQ = tv[i].sel; QEN_REQ = tv[i].qen; VLP_REQ = tv[i].vlp;
      DYN_EN = tv[i].dyn_en; DYN_GATE = tv[i].dyn_gate;
      repeat (tv[i].edges) tick();
      check($sformatf("vec%0d", i), dut_vec(), tv[i].exp);
    end

    // SEL_REQ toggled during SWITCH is ignored until the sequence finishes
    DYN_EN = 0; DYN_GATE = 4'h0; SEL_REQ = 0; QEN_REQ = 4'h3;
    repeat (5) tick();
    check("switch_entered", dut_vec(), mk(0, 4'h0, 4'h0, 4'h0, 4'h0, 1, 0, 0));
    SEL_REQ = 1;
    repeat (8) tick();
    check("latched_target", dut_vec(), mk(0, 4'h3, 4'h0, 4'h0, 4'h0, 1, 1, 0));
    tick();
    check("idle_gap", dut_vec(), mk(0, 4'h3, 4'h0, 4'h0, 4'h0, 0, 0, 0));
    tick();
    check("resequence", dut_vec(), mk(0, 4'h0, 4'h0, 4'h0, 4'h0, 1, 0, 0));
    repeat (4) tick();
    check("resel_switch", dut_vec(), mk(1, 4'h0, 4'h0, 4'h0, 4'h0, 1, 0, 0));

    // reset during SWITCH
    RSTN = 0;
    tick();
    check("mid_reset", dut_vec(), mk(0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 0));
    RSTN = 1;
    tick();
    check("post_reset_seq", dut_vec(), mk(0, 4'h0, 4'h0, 4'h0, 4'h0, 1, 0, 0));
    repeat (14) tick();

    // random requests against the model
    for (int n = 0; n < 3000; n++) begin
      DYN_EN   = 1'($urandom_range(0, 1));
      DYN_GATE = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 11) == 0) begin
        SEL_REQ = 1'($urandom_range(0, 1));
        QEN_REQ = 4'($urandom_range(0, 15));
        VLP_REQ = ($urandom_range(0, 3) == 0);
      end
      RSTN = ($urandom_range(0, 299) != 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
